// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-serial program load, then 10-byte fetch windows.
// Optional load checksum port ld_sum under IMEM_LOAD_CHECKSUM_EN.
module imem_responder #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned WIN_BYTES = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [63:0]            ld_addr,
  input  logic [7:0]             ld_data,
  input  logic                   ld_done,
  output logic                   ld_err,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [63:0]            req_pc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*WIN_BYTES-1:0] rsp_inst,
  output logic                   rsp_imem_er
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]             ld_sum
`endif
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int WW = 8 * WIN_BYTES;

  typedef enum logic {
    LOAD,
    SERVE
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [MEM_BYTES];
  logic            ld_err_q;
  logic            rsp_valid_q;
  logic [WW-1:0]   rsp_inst_q;
  logic            rsp_er_q;

  logic            ld_fire;
  logic            ld_inr;
  logic            req_fire;
  logic [WW-1:0]   win_d;
  logic            win_er_d;
  logic [64:0]     lane;

  assign ld_inr   = ld_addr < 64'(MEM_BYTES);
  assign ld_fire  = (state_q == LOAD) && ld_valid;
  assign req_ready = (state_q == SERVE) &&
                     (!rsp_valid_q || rsp_ready);
  assign req_fire = req_valid && req_ready;

  assign ld_ready    = (state_q == LOAD);
  assign ld_err      = ld_err_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_inst    = rsp_inst_q;
  assign rsp_imem_er = rsp_er_q;

  // 65-bit lane addresses so a PC near 2^64 never wraps back into range
  always_comb begin
    win_d = '0;
    lane  = '0;
    for (int k = 0; k < int'(WIN_BYTES); k++) begin
      lane = {1'b0, req_pc} + 65'(k);
      if (lane < 65'(MEM_BYTES)) begin
        win_d[8*(int'(WIN_BYTES)-1-k) +: 8] = mem_q[lane[AW-1:0]];
      end
    end
    win_er_d = ({1'b0, req_pc} + 65'(WIN_BYTES - 1)) >=
               65'(MEM_BYTES);
  end

  // Storage has no reset so a reload after rst may be partial
  always_ff @(posedge clk) begin
    if (!rst && ld_fire && ld_inr) begin
      mem_q[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ld_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_er_q    <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (ld_valid && !ld_inr) begin
            ld_err_q <= 1'b1;
          end
          if (ld_done) begin
            state_q <= SERVE;
          end
        end
        SERVE: begin
          if (req_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= win_d;
            rsp_er_q    <= win_er_d;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else if (ld_fire && ld_inr) begin
      sum_q <= sum_q + ld_data;
    end
  end

  assign ld_sum = sum_q;
`endif

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the Y86-64 pipeline: the memory-side end of the fetch interface. After reset it accepts a byte-serial program load. It then serves fetch requests by returning the 10-byte instruction window starting at the requested PC, with a one-cycle registered latency and a valid/ready handshake on both sides. It replaces the fetch stage's private `insmem` array, so fetch only decodes and never owns storage.

## Interface
Parameters:
- `MEM_BYTES`, 2048: byte capacity of instruction memory (addresses 0..MEM_BYTES-1).
- `WIN_BYTES`, 10: bytes returned per fetch, which is the maximum Y86-64 instruction length.

Ports:
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: reset, synchronous and active-high.
- `ld_valid` input 1: loader byte present.
- `ld_ready` output 1: loader byte can be accepted.
- `ld_addr` input 64: byte address of the loader byte.
- `ld_data` input 8: loader byte.
- `ld_done` input 1: load complete; sampled only in LOAD state.
- `ld_err` output 1: sticky; a loader byte addressed ≥ MEM_BYTES was dropped.
- `req_valid` input 1: fetch request present.
- `req_ready` output 1: request can be accepted.
- `req_pc` input 64: fetch PC.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: fetch consumes the response.
- `rsp_inst` output 80: instruction window. Byte at PC is in [79:72], byte at PC+9 is in [7:0].
- `rsp_imem_er` output 1: window not fully inside memory.
- `ld_sum` output 8: present only under `IMEM_LOAD_CHECKSUM_EN`.

## Operation
- FSM states: LOAD and SERVE. Reset enters LOAD.
- LOAD state:
  - `ld_ready`=1 and `req_ready`=0.
  - Each cycle with `ld_valid`, if `ld_addr` < MEM_BYTES, write `mem[ld_addr]`=`ld_data`. Otherwise drop the byte and set `ld_err`.
  - `ld_done`=1 transitions to SERVE on the next edge.
  - If `ld_valid` and `ld_done` are both 1 in the same cycle, the byte is written first, then the block enters SERVE.
- SERVE state:
  - `ld_ready`=0. Loader inputs are ignored, and `ld_done` is ignored.
  - `req_ready` = !`rsp_valid` || `rsp_ready`, giving a one-deep output register.
  - On an accepted request, at the next edge the block sets `rsp_valid`=1 and updates `rsp_inst` and `rsp_imem_er`.
  - When `rsp_ready`=1 and no new request is accepted, `rsp_valid` clears.
  - While `rsp_valid`=1 and `rsp_ready`=0, `rsp_inst` and `rsp_imem_er` are held unchanged.
- Range rule:
  - `rsp_imem_er`=1 iff `req_pc` + 9 ≥ MEM_BYTES.
  - The compare uses 65-bit arithmetic, so `req_pc` near 2^64-1 cannot wrap into range.
  - Each byte lane whose address is ≥ MEM_BYTES returns 8'h00. In-range lanes still return memory contents.
- Memory contents are not cleared by `rst`. Only control state is reset.

## Timing
- Reset values:
  - state = LOAD
  - `ld_ready`=1 (in LOAD)
  - `ld_err`=0
  - `req_ready`=0
  - `rsp_valid`=0
  - `rsp_inst`=0
  - `rsp_imem_er`=0
  - `ld_sum`=0
- Loader write takes effect at the accepting edge. A byte written in cycle N is readable by a request accepted in cycle N+1 or later.
- Fetch latency: request accepted at edge N, response visible after edge N, sampled by fetch at edge N+1.
- Throughput: one response per cycle when `rsp_ready` is held at 1.
- `rst` asserted mid-SERVE:
  - The pending response is dropped (`rsp_valid`=0 after the edge).
  - State returns to LOAD.
  - Memory is retained, so a reload may be partial.
- `rst` has priority over all other inputs in the same cycle.

## Configuration
- `IMEM_LOAD_CHECKSUM_EN` defined:
  - Port `ld_sum` exists.
  - `ld_sum` is a mod-256 running sum of every accepted in-range loader byte since reset.
  - Dropped bytes are excluded.
  - `ld_sum` is held in SERVE.
- `IMEM_LOAD_CHECKSUM_EN` not defined:
  - No `ld_sum` port and no accumulator.
  - All other behaviour is identical.

## Test plan
- **Load and single fetch:** load bytes 48,240,0,0,0,0,0,0,0,4 at addresses 0..9, pulse `ld_done`, request PC=0.
  - Expect `rsp_inst`=80'h30F0_0000_0000_0000_0004 and `rsp_imem_er`=0, one cycle after acceptance.
  - With the macro: `ld_sum`=8'h24 (292 mod 256=36).
- **Back-to-back streaming:** after loading addresses 20..23 = 96,3,96,3, issue requests at PC 20, 21, 22 on consecutive cycles with `rsp_ready`=1.
  - Expect three consecutive `rsp_valid` cycles.
  - First response has `rsp_inst`[79:48]=32'h6003_6003.
- **Backpressure:** hold `rsp_ready`=0 after one response.
  - Expect `req_ready`=0 and `rsp_inst` stable for 5 cycles.
  - Raising `rsp_ready` with a new request pending gives the new response on the next edge, with no gap and no duplicate.
- **Boundary:** request PC=2038.
  - Expect `rsp_imem_er`=0.
- **Boundary:** request PC=2039.
  - Expect `rsp_imem_er`=1 and `rsp_inst`[7:0]=0.
- **Boundary:** request PC=64'hFFFF_FFFF_FFFF_FFFA.
  - Expect `rsp_imem_er`=1 and `rsp_inst`=0.
- **Load error:** loader byte at `ld_addr`=2048.
  - Expect `ld_err`=1 sticky, memory unchanged, `ld_sum` unchanged.
- **Reset mid-operation:** assert `rst` while `rsp_valid`=1.
  - Next cycle: `rsp_valid`=0, `req_ready`=0, `ld_ready`=1.
  - A request at PC=0 after a new `ld_done` returns the original bytes, since memory is retained.
